// File: rtl/fault_pkg.sv
// Shared definitions for the fault handling blocks: recovery FSM states,
// default recovery constants and the opcode classes seen by fault_detector.
package fault_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_FLUSH       = 3'd1,
        ST_REPLAY      = 3'd2,
        ST_WAIT_COMMIT = 3'd3,
        ST_TRAP        = 3'd4
    } fsm_state_e;

    localparam int          DEF_MAX_RETRY    = 2;
    localparam int          DEF_FLUSH_CYCLES = 2;
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

    localparam int FAULT_CNT_W = 8;

    // Opcode classes the detector watches for faulting accesses.
    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_AMO    = 7'b010_1111;
    localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for error statistics; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             i_inc,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] COUNT_MAX = '1;

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (srst || i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != COUNT_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fault_recovery_ctrl.sv
// Pipeline fault recovery: flush, replay the faulting PC a bounded number of
// times, then trap. Outputs are registered from the next state (Moore).
module fault_recovery_ctrl
    import fault_pkg::*;
#(
    parameter int          MAX_RETRY    = DEF_MAX_RETRY,
    parameter int          FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter logic [31:0] TRAP_VECTOR  = DEF_TRAP_VECTOR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fault_detected,
    input  logic [31:0]            fault_pc,
    input  logic                   retire_valid,
    output logic                   stall,
    output logic                   flush,
    output logic                   redirect_valid,
    output logic [31:0]            redirect_pc,
    output logic                   trap_flag,
    output logic [FAULT_CNT_W-1:0] fault_count
);

    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);
    localparam logic [3:0] FLUSH_LAST  = 4'(FLUSH_CYCLES - 1);

    fsm_state_e  r_state, w_state_next;
    logic [3:0]  r_flush_cnt, w_flush_cnt_next;
    logic [2:0]  r_retry_cnt, w_retry_cnt_next;
    logic [31:0] r_saved_pc, w_saved_pc_next;
    logic        w_fault_accept;

    logic        r_stall, w_stall_next;
    logic        r_flush, w_flush_next;
    logic        r_redirect_valid, w_redirect_valid_next;
    logic [31:0] r_redirect_pc, w_redirect_pc_next;
    logic        r_trap_flag, w_trap_flag_next;

    always_comb begin
        w_state_next     = r_state;
        w_flush_cnt_next = r_flush_cnt;
        w_retry_cnt_next = r_retry_cnt;
        w_saved_pc_next  = r_saved_pc;
        w_fault_accept   = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (fault_detected) begin
                    w_fault_accept   = 1'b1;
                    w_saved_pc_next  = fault_pc;
                    w_flush_cnt_next = '0;
                    w_state_next     = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (r_flush_cnt == FLUSH_LAST) begin
                    w_state_next = (r_retry_cnt < RETRY_LIMIT) ? ST_REPLAY : ST_TRAP;
                end else begin
                    w_flush_cnt_next = r_flush_cnt + 1'b1;
                end
            end
            ST_REPLAY: begin
                w_retry_cnt_next = r_retry_cnt + 1'b1;
                w_state_next     = ST_WAIT_COMMIT;
            end
            ST_WAIT_COMMIT: begin
                // A re-fault keeps the retry budget so a persistent fault ends in a trap.
                if (fault_detected) begin
                    w_fault_accept   = 1'b1;
                    w_saved_pc_next  = fault_pc;
                    w_flush_cnt_next = '0;
                    w_state_next     = ST_FLUSH;
                end else if (retire_valid) begin
                    w_retry_cnt_next = '0;
                    w_state_next     = ST_IDLE;
                end
            end
            ST_TRAP: begin
                w_retry_cnt_next = '0;
                w_state_next     = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the state being entered so they line up with it.
    always_comb begin
        w_stall_next          = 1'b0;
        w_flush_next          = 1'b0;
        w_redirect_valid_next = 1'b0;
        w_redirect_pc_next    = r_redirect_pc;
        w_trap_flag_next      = r_trap_flag;

        unique case (w_state_next)
            ST_FLUSH: begin
                w_stall_next = 1'b1;
                w_flush_next = 1'b1;
            end
            ST_REPLAY: begin
                w_stall_next          = 1'b1;
                w_redirect_valid_next = 1'b1;
                w_redirect_pc_next    = r_saved_pc;
            end
            ST_TRAP: begin
                w_stall_next          = 1'b1;
                w_flush_next          = 1'b1;
                w_redirect_valid_next = 1'b1;
                w_redirect_pc_next    = TRAP_VECTOR;
                w_trap_flag_next      = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_flush_cnt      <= '0;
            r_retry_cnt      <= '0;
            r_saved_pc       <= '0;
            r_stall          <= 1'b0;
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_trap_flag      <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_flush_cnt      <= w_flush_cnt_next;
            r_retry_cnt      <= w_retry_cnt_next;
            r_saved_pc       <= w_saved_pc_next;
            r_stall          <= w_stall_next;
            r_flush          <= w_flush_next;
            r_redirect_valid <= w_redirect_valid_next;
            r_redirect_pc    <= w_redirect_pc_next;
            r_trap_flag      <= w_trap_flag_next;
        end
    end

    sat_counter #(
        .WIDTH (FAULT_CNT_W)
    ) u_fault_count (
        .clk     (clk),
        .srst    (rst),
        .i_inc   (w_fault_accept),
        .i_clear (1'b0),
        .o_count (fault_count)
    );

    assign stall          = r_stall;
    assign flush          = r_flush;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign trap_flag      = r_trap_flag;

endmodule

// File: tb/tb_fault_recovery_ctrl.sv
// Bench for fault_recovery_ctrl: per-edge expectations from a timeline model
// are queued by the driver and checked by an independent negedge monitor.
module tb_fault_recovery_ctrl;

    localparam int          F  = 2;
    localparam int          MR = 2;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fault_detected = 1'b0;
    logic [31:0] fault_pc = '0;
    logic        retire_valid = 1'b0;
    logic        stall, flush, redirect_valid, trap_flag;
    logic [31:0] redirect_pc;
    logic [7:0]  fault_count;

    fault_recovery_ctrl #(
        .MAX_RETRY    (MR),
        .FLUSH_CYCLES (F),
        .TRAP_VECTOR  (TV)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fault_detected (fault_detected),
        .fault_pc       (fault_pc),
        .retire_valid   (retire_valid),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_flag      (trap_flag),
        .fault_count    (fault_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        rv;
        logic [31:0] rpc;
        logic        trap;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Timeline model: an accepted fault at edge s opens a window where edges
    // s..s+F-1 flush, edge s+F redirects, and faults are ignored through s+F+1.
    int          edge_no = 0;
    int          start   = -100;
    bit          outcome_trap = 0;
    int          retries = 0;
    bit          waiting = 0;
    int          count   = 0;
    bit          trapped = 0;
    logic [31:0] saved   = '0;
    logic [31:0] m_rpc   = '0;

    task model_edge(input bit r, input bit f, input logic [31:0] pc, input bit ret);
        exp_t e;
        int   d;
        edge_no++;
        if (r) begin
            count = 0; trapped = 0; m_rpc = '0; retries = 0;
            waiting = 0; start = -100; saved = '0;
        end else if (edge_no - start > F + 1) begin
            if (f) begin
                count        = (count < 255) ? count + 1 : 255;
                saved        = pc;
                start        = edge_no;
                waiting      = 0;
                outcome_trap = (retries >= MR);
            end else if (ret && waiting) begin
                retries = 0;
                waiting = 0;
            end
        end
        e = '0;
        d = edge_no - start;
        if (!r && d >= 0 && d < F) begin
            e.stall = 1'b1;
            e.flush = 1'b1;
        end else if (!r && d == F) begin
            e.stall = 1'b1;
            e.rv    = 1'b1;
            if (outcome_trap) begin
                e.flush = 1'b1;
                m_rpc   = TV;
                trapped = 1;
                retries = 0;
            end else begin
                m_rpc   = saved;
                retries = retries + 1;
                waiting = 1;
            end
        end
        e.rpc  = m_rpc;
        e.trap = trapped;
        e.cnt  = 8'(count);
        sb.push_back(e);
    endtask

    task step(input bit r, input bit f, input logic [31:0] pc, input bit ret);
        @(negedge clk);
        #1;
        rst            = r;
        fault_detected = f;
        fault_pc       = pc;
        retire_valid   = ret;
        model_edge(r, f, pc, ret);
    endtask

    task idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t x;
        exp_t got;
        if (sb.size() > 0) begin
            x   = sb.pop_front();
            got = {stall, flush, redirect_valid, redirect_pc, trap_flag, fault_count};
            n_tests++;
            if (got !== x) begin
                n_fail++;
                $display("FAIL outputs edge %0d: got stall=%b flush=%b rv=%b pc=%h trap=%b cnt=%0d, required stall=%b flush=%b rv=%b pc=%h trap=%b cnt=%0d",
                         edge_no, got.stall, got.flush, got.rv, got.rpc, got.trap, got.cnt,
                         x.stall, x.flush, x.rv, x.rpc, x.trap, x.cnt);
            end
        end
    end

    initial begin
        // Reset state
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'hDEAD_BEE0, 1'b1);
        idle(3);

        // Single fault, replay, retire
        step(1'b0, 1'b1, 32'h40, 1'b0);
        idle(4);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        idle(2);

        // Persistent fault: two replays then trap
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 32'h40, 1'b0);
        idle(4);

        // Reset in the first flush cycle clears trap and suppresses redirect
        step(1'b0, 1'b1, 32'h80, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        idle(5);

        // Fault held through flush with changing PC
        step(1'b0, 1'b1, 32'h40, 1'b0);
        step(1'b0, 1'b1, 32'h80, 1'b0);
        step(1'b0, 1'b1, 32'hC0, 1'b0);
        idle(2);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        idle(2);

        // Fault and retire together in WAIT_COMMIT keep the retry budget
        step(1'b0, 1'b1, 32'h40, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 32'h44, 1'b1);
        idle(3);
        step(1'b0, 1'b1, 32'h48, 1'b1);
        idle(6);

        // Saturation of fault_count
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, 1'b0);
            idle(3);
            step(1'b0, 1'b0, 32'h0, 1'b1);
            idle(1);
        end

        // Random traffic
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) == 0),
                 {$urandom(), 2'b00} >> 2 << 2,
                 ($urandom_range(0, 2) == 0));
        end
        idle(2);

        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fault_recovery_ctrl.md
FAULT_RECOVERY_CTRL -- requirements
Module: fault_recovery_ctrl

Interface
REQ-001 Parameter MAX_RETRY, default 2, replay attempts allowed per fault before trapping (range 0..7).
REQ-002 Parameter FLUSH_CYCLES, default 2, cycles flush/stall held per recovery (range 1..15).
REQ-003 Parameter TRAP_VECTOR, default 32'h0000_0100, redirect target when retries are exhausted.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 fault_detected  input  1  level from the fault detector; sampled each clk.
REQ-007 fault_pc  input  32  PC of the faulting instruction; valid when fault_detected=1.
REQ-008 retire_valid  input  1  an instruction retired without a fault this cycle.
REQ-009 stall  output  1  freeze fetch/decode.
REQ-010 flush  output  1  kill in-flight pipeline stages.
REQ-011 redirect_valid  output  1  one-cycle pulse; fetch loads redirect_pc.
REQ-012 redirect_pc  output  32  replay or trap target.
REQ-013 trap_flag  output  1  sticky; an unrecoverable fault has occurred.
REQ-014 fault_count  output  8  saturating count of accepted faults.

Function
REQ-015 The FSM SHALL have the states IDLE, FLUSH, REPLAY, WAIT_COMMIT and TRAP; all outputs SHALL be registered (Moore).
REQ-016 IDLE: when fault_detected=1, latch fault_pc into saved_pc, increment fault_count, clear flush_cnt, and go to FLUSH. Otherwise stay in IDLE.
REQ-017 Latency: a fault sampled at edge N SHALL produce stall=flush=1 in the cycle after edge N.
REQ-018 FLUSH: stall=1 and flush=1 for exactly FLUSH_CYCLES cycles. Then go to REPLAY if retry_cnt<MAX_RETRY, else go to TRAP.
REQ-019 REPLAY: lasts one cycle with redirect_valid=1, redirect_pc=saved_pc, stall=1 and flush=0. retry_cnt increments. Next state is WAIT_COMMIT.
REQ-020 WAIT_COMMIT: stall=0 and flush=0.
- fault_detected=1: relatch fault_pc, increment fault_count, go to FLUSH, and keep retry_cnt.
- Else retire_valid=1: clear retry_cnt and go to IDLE.
- Simultaneous fault and retire: the fault wins.
REQ-021 TRAP: lasts one cycle with redirect_valid=1, redirect_pc=TRAP_VECTOR, stall=1 and flush=1. trap_flag is set, retry_cnt clears, and the next state is IDLE.
REQ-022 fault_detected SHALL be ignored in FLUSH, REPLAY and TRAP (pipeline is being killed); fault_count SHALL NOT change in those states.
REQ-023 fault_count SHALL saturate at 255 and never wrap.
REQ-024 MAX_RETRY=0 SHALL go FLUSH->TRAP on the first fault with no REPLAY.
REQ-025 redirect_pc SHALL hold its last value when redirect_valid=0.
REQ-026 trap_flag SHALL clear only on rst.

Reset
REQ-027 With rst=1 at a clk edge:
- state=IDLE
- stall=flush=redirect_valid=trap_flag=0
- redirect_pc=32'h0, fault_count=0
- retry_cnt=0, flush_cnt=0, saved_pc=0
REQ-028 rst asserted mid-recovery SHALL abort immediately to IDLE with no trailing redirect pulse. rst SHALL override fault_detected in the same cycle.

Structure
REQ-029 State encodings and the default TRAP_VECTOR, MAX_RETRY and FLUSH_CYCLES constants SHALL live in shared package fault_pkg, alongside the opcode constants used by fault_detector.
REQ-030 The fault_count saturating counter SHALL be a sub-module sat_counter (width parameter, inc, clear) reusable for other error counters. The FSM stays in fault_recovery_ctrl.

Verification
REQ-031 Single fault then retire: fault_pc=32'h40 at cycle 5.
- flush=1 in cycles 6-7
- redirect_valid=1 with redirect_pc=32'h40 in cycle 8
- retire_valid in cycle 10 -> IDLE, fault_count=1, trap_flag=0.
REQ-032 Persistent fault, MAX_RETRY=2: fault re-asserted in WAIT_COMMIT after each replay.
- Exactly 2 replays to 32'h40
- Then redirect_pc=32'h100 with trap_flag=1
- fault_count=3.
REQ-033 Fault held high during FLUSH: fault_count increments once and saved_pc is unchanged.
REQ-034 fault_detected and retire_valid both high in WAIT_COMMIT: state goes to FLUSH and retry_cnt is not cleared.
REQ-035 rst pulsed during FLUSH cycle 1: next cycle all outputs are 0, no redirect follows, and trap_flag is cleared.
REQ-036 300 isolated recovered faults: fault_count=255 and does not wrap.
